sdram_traffic_gen: RTL and testbench

- Synthesizable, parametrised traffic generator and checker for the sdram_controller AXI-lite-style slave ports.
- Runs a write pass of COUNT words from a programmable base address, then a read-back pass with pipelined reads, comparing each returned word against a pattern from a selectable generator.
- Used in simulation and on-board bring-up in place of hand-written write/read sequences; reports pass/fail and first failing address.

---
 rtl/sdram_traffic_gen.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_traffic_gen.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_traffic_gen.sv
// Traffic generator/checker for the sdram_controller slave ports: writes COUNT
// patterned words, reads them back with pipelined reads and tallies mismatches.
module sdram_traffic_gen #(
    parameter int unsigned ADDR_WIDTH      = 25,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [63:0] LFSR_SEED       = 64'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rvalid,
    output logic                  m_rready
);
    localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [DATA_WIDTH-1:0] SEED = LFSR_SEED[DATA_WIDTH-1:0];

    // Galois feedback masks of maximal-length polynomials for common widths
    function automatic logic [DATA_WIDTH-1:0] lfsr_taps();
        case (DATA_WIDTH)
            8:       return DATA_WIDTH'(8'hB8);
            24:      return DATA_WIDTH'(24'hE10000);
            32:      return DATA_WIDTH'(32'hA3000000);
            default: return DATA_WIDTH'(16'hB400);
        endcase
    endfunction

    localparam logic [DATA_WIDTH-1:0] TAPS = lfsr_taps();

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0]            md,
                                                      input logic [CNT_WIDTH-1:0]  idx,
                                                      input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [DATA_WIDTH-1:0] lfsr);
        case (md)
            2'd0:    return DATA_WIDTH'(idx);
            2'd1:    return DATA_WIDTH'(addr);
            2'd2:    return lfsr;
            default: return ~DATA_WIDTH'(addr);
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  w_idx;
    logic [DATA_WIDTH-1:0] w_lfsr;
    logic [CNT_WIDTH-1:0]  ar_cnt;
    logic [OUT_WIDTH-1:0]  outstanding;
    logic [CNT_WIDTH-1:0]  rd_idx;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_lfsr;

    logic                  accept, aw_hs, w_hs, ar_hs, r_hs;
    logic                  word_done, w_last, r_last;
    logic [OUT_WIDTH-1:0]  outstanding_n;
    logic [CNT_WIDTH-1:0]  ar_cnt_n;
    logic [DATA_WIDTH-1:0] exp_data;

    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign aw_hs     = m_awvalid && m_awready;
    assign w_hs      = m_wvalid && m_wready;
    assign ar_hs     = m_arvalid && m_arready;
    assign r_hs      = (state_q == READ) && m_rvalid && m_rready;
    // A word retires once each channel has either just handshaken or already did
    assign word_done = (state_q == WRITE) && (!m_awvalid || m_awready) && (!m_wvalid || m_wready);
    assign w_last    = (w_idx == count_q - CNT_WIDTH'(1));
    assign r_last    = (rd_idx == count_q - CNT_WIDTH'(1));
    assign outstanding_n = outstanding + OUT_WIDTH'(ar_hs) - OUT_WIDTH'(r_hs);
    assign ar_cnt_n  = ar_cnt + CNT_WIDTH'(ar_hs);
    assign exp_data  = pattern(mode_q, rd_idx, rd_addr, rd_lfsr);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (count == '0) ? DONE : WRITE;
            WRITE:      if (word_done && w_last) state_d = READ;
            READ:       if (r_hs && r_last) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            m_awaddr       <= '0;
            m_awvalid      <= 1'b0;
            m_wdata        <= '0;
            m_wvalid       <= 1'b0;
            m_araddr       <= '0;
            m_arvalid      <= 1'b0;
            m_rready       <= 1'b0;
            mode_q         <= '0;
            count_q        <= '0;
            w_idx          <= '0;
            w_lfsr         <= '0;
            ar_cnt         <= '0;
            outstanding    <= '0;
            rd_idx         <= '0;
            rd_addr        <= '0;
            rd_lfsr        <= '0;
        end else begin
            if (accept) begin
                mode_q         <= mode;
                count_q        <= count;
                busy           <= (count != '0);
                done           <= (count == '0);
                error          <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
                m_awaddr       <= base_addr;
                m_araddr       <= base_addr;
                rd_addr        <= base_addr;
                w_idx          <= '0;
                ar_cnt         <= '0;
                rd_idx         <= '0;
                outstanding    <= '0;
                w_lfsr         <= SEED;
                rd_lfsr        <= SEED;
                m_wdata        <= pattern(mode, CNT_WIDTH'(0), base_addr, SEED);
                m_awvalid      <= (count != '0);
                m_wvalid       <= (count != '0);
            end

            if (state_q == WRITE) begin
                if (word_done) begin
                    if (w_last) begin
                        m_awvalid <= 1'b0;
                        m_wvalid  <= 1'b0;
                        m_arvalid <= 1'b1;
                        m_rready  <= 1'b1;
                    end else begin
                        w_idx     <= w_idx + CNT_WIDTH'(1);
                        m_awaddr  <= m_awaddr + ADDR_WIDTH'(1);
                        w_lfsr    <= lfsr_step(w_lfsr);
                        m_wdata   <= pattern(mode_q, w_idx + CNT_WIDTH'(1),
                                             m_awaddr + ADDR_WIDTH'(1), lfsr_step(w_lfsr));
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                    end
                end else begin
                    if (aw_hs) m_awvalid <= 1'b0;
                    if (w_hs)  m_wvalid  <= 1'b0;
                end
            end

            if (state_q == READ) begin
                outstanding <= outstanding_n;
                ar_cnt      <= ar_cnt_n;
                if (ar_hs) m_araddr <= m_araddr + ADDR_WIDTH'(1);
                // A pending request stays valid: outstanding can only fall until it is taken
                m_arvalid   <= (ar_cnt_n < count_q) && (outstanding_n < OUT_WIDTH'(MAX_OUTSTANDING));
                if (r_hs) begin
                    rd_idx  <= rd_idx + CNT_WIDTH'(1);
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    rd_lfsr <= lfsr_step(rd_lfsr);
                    if (m_rdata != exp_data) begin
                        error <= 1'b1;
                        if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
                        if (!error) first_err_addr <= rd_addr;
                    end
                    if (r_last) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        m_rready  <= 1'b0;
                        m_arvalid <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Bench for sdram_traffic_gen: randomized memory slave on the bus, with every run
// compared against a word-by-word reference of what that run should produce.
`timescale 1ns/1ps
module tb_sdram_traffic_gen;
    localparam int unsigned AW = 25;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned MO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] count = '0;
    logic          busy, done, error;
    logic [CW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata;
    logic          m_awvalid, m_wvalid, m_arvalid, m_rready;
    logic          m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    always #5 clk = ~clk;

    sdram_traffic_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW),
        .MAX_OUTSTANDING(MO), .LFSR_SEED(64'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .error(error), .err_count(err_count),
        .first_err_addr(first_err_addr),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int checks = 0;
    int errors = 0;

    // Slave knobs, written only by the test tasks
    int            p_aw = 100, p_w = 100, p_ar = 100, r_lat = 1, ar_cap = 0;
    bit            corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    bit            log_clr = 1'b0;

    // Slave state and logs, written only by the slave process
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] aw_pend[$], rd_addr_q[$], wr_addr_log[$], ar_log[$];
    logic [DW-1:0] w_pend[$], wr_data_log[$];
    int            rd_due_q[$];
    int            cyc = 0, outst = 0, max_out = 0, stab_err = 0;
    bit            aw_hold = 0, w_hold = 0, ar_hold = 0;
    logic [AW-1:0] hold_awaddr = '0, hold_araddr = '0;
    logic [DW-1:0] hold_wdata = '0;

    // Reference run, written only by the test process
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    // Slave acts at negedge: handshakes it records here complete at the next posedge
    always @(negedge clk) begin : slave
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        cyc++;
        if (log_clr) begin
            wr_addr_log.delete(); wr_data_log.delete(); ar_log.delete();
            max_out = 0; stab_err = 0;
        end
        if (!reset) begin
            if (aw_hold && (m_awvalid !== 1'b1 || m_awaddr !== hold_awaddr)) stab_err++;
            if (w_hold && (m_wvalid !== 1'b1 || m_wdata !== hold_wdata)) stab_err++;
            if (ar_hold && (m_arvalid !== 1'b1 || m_araddr !== hold_araddr)) stab_err++;
        end
        if (reset) begin
            aw_pend.delete(); w_pend.delete(); rd_addr_q.delete(); rd_due_q.delete();
            outst = 0;
            m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
            aw_hold = 0; w_hold = 0; ar_hold = 0;
        end else begin
            m_awready = ($urandom_range(99) < p_aw);
            m_wready  = ($urandom_range(99) < p_w);
            m_rvalid  = 1'b0;
            if (rd_addr_q.size() != 0 && cyc >= rd_due_q[0]) begin
                a = rd_addr_q[0];
                d = mem.exists(a) ? mem[a] : '0;
                if (corrupt_en && a == corrupt_addr) d[0] = ~d[0];
                m_rvalid = 1'b1;
                m_rdata  = d;
                if (m_rready) begin
                    void'(rd_addr_q.pop_front());
                    void'(rd_due_q.pop_front());
                    outst--;
                end
            end
            m_arready = (ar_cap == 0 || outst < ar_cap) && ($urandom_range(99) < p_ar);
            if (m_awvalid && m_awready) aw_pend.push_back(m_awaddr);
            if (m_wvalid && m_wready) w_pend.push_back(m_wdata);
            while (aw_pend.size() != 0 && w_pend.size() != 0) begin
                a = aw_pend.pop_front();
                d = w_pend.pop_front();
                mem[a] = d;
                wr_addr_log.push_back(a);
                wr_data_log.push_back(d);
            end
            if (m_arvalid && m_arready) begin
                ar_log.push_back(m_araddr);
                rd_addr_q.push_back(m_araddr);
                rd_due_q.push_back(cyc + r_lat);
                outst++;
                if (outst > max_out) max_out = outst;
            end
            aw_hold = m_awvalid && !m_awready; hold_awaddr = m_awaddr;
            w_hold  = m_wvalid && !m_wready;   hold_wdata  = m_wdata;
            ar_hold = m_arvalid && !m_arready; hold_araddr = m_araddr;
        end
    end

    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Word i lives at base+i (mod 2^AW); data per mode, LFSR word 0 is the seed
    task automatic build_ref(input logic [1:0] md, input logic [AW-1:0] base, input int n);
        logic [DW-1:0] lf = 16'hACE1;
        logic [AW-1:0] a;
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            exp_addr.push_back(a);
            case (md)
                2'd0:    exp_data.push_back(DW'(i));
                2'd1:    exp_data.push_back(a[DW-1:0]);
                2'd2:    exp_data.push_back(lf);
                default: exp_data.push_back(~a[DW-1:0]);
            endcase
            lf = lfsr_next(lf);
        end
    endtask

    task automatic start_run(input logic [1:0] md, input logic [AW-1:0] base, input int n);
        mode = md; base_addr = base; count = CW'(n);
        start = 1'b1; log_clr = 1'b1;
        build_ref(md, base, n);
        @(posedge clk); #1;
        start = 1'b0; log_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, error, m_awvalid, m_wvalid, m_arvalid, m_rready} !== 7'b0 ||
            err_count !== '0 || first_err_addr !== '0 || m_awaddr !== '0 || m_araddr !== '0 || m_wdata !== '0) begin
            $display("FAIL reset_state: busy=%b done=%b error=%b aw/w/ar valid=%b%b%b rready=%b err_count=%0d first=%h, expected all zero",
                     busy, done, error, m_awvalid, m_wvalid, m_arvalid, m_rready, err_count, first_err_addr);
            errors++;
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
            errors++;
        end
    endtask

    task automatic test_basic();
        bit ok;
        start_run(2'd0, 25'd1, 3);
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy: busy=%b, expected 1 after start", busy);
            errors++;
        end
        wait_done(200, ok);
        checks++;
        if (!ok) begin $display("FAIL basic_done: done=%b, expected 1 within 200 cycles", done); errors++; end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0 || err_count !== '0) begin
            $display("FAIL basic_status: busy=%b error=%b err_count=%0d, expected 0 0 0", busy, error, err_count);
            errors++;
        end
        checks++;
        if (wr_addr_log.size() != 3 || ar_log.size() != 3) begin
            $display("FAIL basic_counts: writes=%0d reads=%0d, expected 3 3", wr_addr_log.size(), ar_log.size());
            errors++;
        end
        for (int i = 0; i < 3 && i < wr_addr_log.size() && i < ar_log.size(); i++) begin
            checks++;
            if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== exp_data[i] || ar_log[i] !== exp_addr[i]) begin
                $display("FAIL basic_word%0d: wr %h=%h rd %h, expected %h=%h rd %h", i,
                         wr_addr_log[i], wr_data_log[i], ar_log[i], exp_addr[i], exp_data[i], exp_addr[i]);
                errors++;
            end
        end
    endtask

    task automatic test_stalls();
        bit ok;
        p_aw = 50; p_w = 50; p_ar = 60; r_lat = int'($urandom_range(3, 1));
        start_run(2'd1, AW'($urandom), 64);
        wait_done(4000, ok);
        checks++;
        if (!ok) begin $display("FAIL stalls_done: done=%b, expected 1 within 4000 cycles", done); errors++; end
        checks++;
        if (error !== 1'b0 || err_count !== '0) begin
            $display("FAIL stalls_error: error=%b err_count=%0d, expected 0 0", error, err_count);
            errors++;
        end
        checks++;
        if (wr_addr_log.size() != 64 || ar_log.size() != 64) begin
            $display("FAIL stalls_counts: writes=%0d reads=%0d, expected 64 64", wr_addr_log.size(), ar_log.size());
            errors++;
        end
        for (int i = 0; i < 64 && i < wr_addr_log.size() && i < ar_log.size(); i++) begin
            checks++;
            if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== exp_data[i] || ar_log[i] !== exp_addr[i]) begin
                $display("FAIL stalls_word%0d: wr %h=%h rd %h, expected %h=%h rd %h", i,
                         wr_addr_log[i], wr_data_log[i], ar_log[i], exp_addr[i], exp_data[i], exp_addr[i]);
                errors++;
            end
        end
        checks++;
        if (stab_err != 0) begin
            $display("FAIL stalls_stability: %0d valid/payload changes before handshake, expected 0", stab_err);
            errors++;
        end
        p_aw = 100; p_w = 100; p_ar = 100; r_lat = 1;
    endtask

    task automatic test_corrupt();
        bit ok;
        corrupt_en = 1'b1; corrupt_addr = 25'h10;
        start_run(2'd3, 25'h0C, 8);
        wait_done(300, ok);
        checks++;
        if (!ok) begin $display("FAIL corrupt_done: done=%b, expected 1", done); errors++; end
        checks++;
        if (error !== 1'b1 || err_count !== CW'(1)) begin
            $display("FAIL corrupt_errors: error=%b err_count=%0d, expected 1 1", error, err_count);
            errors++;
        end
        checks++;
        if (first_err_addr !== 25'h10) begin
            $display("FAIL corrupt_first_addr: got %h, expected 0000010", first_err_addr);
            errors++;
        end
        for (int i = 0; i < 8 && i < wr_data_log.size(); i++) begin
            checks++;
            if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== exp_data[i]) begin
                $display("FAIL corrupt_word%0d: wr %h=%h, expected %h=%h", i,
                         wr_addr_log[i], wr_data_log[i], exp_addr[i], exp_data[i]);
                errors++;
            end
        end
        corrupt_en = 1'b0;
    endtask

    task automatic test_lfsr();
        bit ok;
        r_lat = 6;
        start_run(2'd2, AW'($urandom), 16);
        wait_done(600, ok);
        checks++;
        if (!ok) begin $display("FAIL lfsr_done: done=%b, expected 1", done); errors++; end
        checks++;
        if (error !== 1'b0 || err_count !== '0 || first_err_addr !== '0) begin
            $display("FAIL lfsr_clean: error=%b err_count=%0d first=%h, expected 0 0 0", error, err_count, first_err_addr);
            errors++;
        end
        checks++;
        if (max_out != MO) begin
            $display("FAIL lfsr_outstanding_peak: got %0d, expected %0d", max_out, MO);
            errors++;
        end
        checks++;
        if (wr_data_log.size() != 16 || ar_log.size() != 16) begin
            $display("FAIL lfsr_counts: writes=%0d reads=%0d, expected 16 16", wr_data_log.size(), ar_log.size());
            errors++;
        end
        for (int i = 0; i < 16 && i < wr_data_log.size(); i++) begin
            checks++;
            if (wr_data_log[i] !== exp_data[i] || wr_addr_log[i] !== exp_addr[i]) begin
                $display("FAIL lfsr_word%0d: wr %h=%h, expected %h=%h", i,
                         wr_addr_log[i], wr_data_log[i], exp_addr[i], exp_data[i]);
                errors++;
            end
        end
        r_lat = 1;
    endtask

    task automatic test_wrap_and_zero();
        bit ok;
        bit any_valid = 1'b0;
        start_run(2'($urandom_range(3)), 25'h1FFFFFE, 4);
        wait_done(200, ok);
        checks++;
        if (!ok || error !== 1'b0) begin $display("FAIL wrap_done: done=%b error=%b, expected 1 0", done, error); errors++; end
        checks++;
        if (wr_addr_log.size() != 4 || ar_log.size() != 4) begin
            $display("FAIL wrap_counts: writes=%0d reads=%0d, expected 4 4", wr_addr_log.size(), ar_log.size());
            errors++;
        end
        for (int i = 0; i < 4 && i < wr_addr_log.size() && i < ar_log.size(); i++) begin
            checks++;
            if (wr_addr_log[i] !== exp_addr[i] || ar_log[i] !== exp_addr[i] || wr_data_log[i] !== exp_data[i]) begin
                $display("FAIL wrap_word%0d: wr %h=%h rd %h, expected %h=%h", i,
                         wr_addr_log[i], wr_data_log[i], ar_log[i], exp_addr[i], exp_data[i]);
                errors++;
            end
        end
        start_run(2'd1, 25'h40, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            $display("FAIL zero_count_done: done=%b busy=%b error=%b, expected 1 0 0", done, busy, error);
            errors++;
        end
        for (int i = 0; i < 6; i++) begin
            any_valid |= m_awvalid | m_wvalid | m_arvalid | m_rready;
            @(posedge clk); #1;
        end
        checks++;
        if (any_valid || wr_addr_log.size() != 0 || ar_log.size() != 0) begin
            $display("FAIL zero_count_traffic: valid_seen=%b writes=%0d reads=%0d, expected 0 0 0",
                     any_valid, wr_addr_log.size(), ar_log.size());
            errors++;
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        ar_cap = 2; r_lat = 40;
        start_run(2'd0, 25'h100, 16);
        repeat (3) @(posedge clk);
        #1;
        mode = 2'd1; base_addr = 25'h500; count = CW'(3); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(outst == 2 && ar_log.size() == 2) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (n >= 200 || busy !== 1'b1 || outst != 2) begin
            $display("FAIL midrun_reach_read: busy=%b outstanding=%0d waited=%0d, expected 1 2 <200", busy, outst, n);
            errors++;
        end
        checks++;
        if (wr_addr_log.size() != 16 || ar_log.size() != 2) begin
            $display("FAIL midrun_counts: writes=%0d reads=%0d, expected 16 2", wr_addr_log.size(), ar_log.size());
            errors++;
        end
        for (int i = 0; i < 16 && i < wr_addr_log.size(); i++) begin
            checks++;
            if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== exp_data[i]) begin
                $display("FAIL midrun_word%0d: wr %h=%h, expected %h=%h", i,
                         wr_addr_log[i], wr_data_log[i], exp_addr[i], exp_data[i]);
                errors++;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, error, m_awvalid, m_wvalid, m_arvalid, m_rready} !== 7'b0 ||
            err_count !== '0 || first_err_addr !== '0 || m_araddr !== '0) begin
            $display("FAIL midrun_reset: busy=%b done=%b error=%b aw/w/ar valid=%b%b%b rready=%b araddr=%h, expected all zero",
                     busy, done, error, m_awvalid, m_wvalid, m_arvalid, m_rready, m_araddr);
            errors++;
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || m_arvalid !== 1'b0 || m_awvalid !== 1'b0) begin
            $display("FAIL midrun_stays_idle: busy=%b done=%b arvalid=%b awvalid=%b, expected 0 0 0 0",
                     busy, done, m_arvalid, m_awvalid);
            errors++;
        end
        ar_cap = 0; r_lat = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        for (int k = 0; k < 4; k++) begin
            p_aw = int'($urandom_range(100, 30)); p_w = int'($urandom_range(100, 30));
            p_ar = int'($urandom_range(100, 30)); r_lat = int'($urandom_range(4, 1));
            n = int'($urandom_range(24, 1));
            start_run(2'($urandom_range(3)), AW'($urandom), n);
            wait_done(3000, ok);
            checks++;
            if (!ok || error !== 1'b0 || err_count !== '0) begin
                $display("FAIL b2b%0d_status: done=%b error=%b err_count=%0d, expected 1 0 0", k, done, error, err_count);
                errors++;
            end
            checks++;
            if (wr_addr_log.size() != n || ar_log.size() != n || stab_err != 0) begin
                $display("FAIL b2b%0d_counts: writes=%0d reads=%0d stability=%0d, expected %0d %0d 0",
                         k, wr_addr_log.size(), ar_log.size(), stab_err, n, n);
                errors++;
            end
            for (int i = 0; i < n && i < wr_addr_log.size() && i < ar_log.size(); i++) begin
                checks++;
                if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== exp_data[i] || ar_log[i] !== exp_addr[i]) begin
                    $display("FAIL b2b%0d_word%0d: wr %h=%h rd %h, expected %h=%h", k, i,
                             wr_addr_log[i], wr_data_log[i], ar_log[i], exp_addr[i], exp_data[i]);
                    errors++;
                end
            end
        end
        p_aw = 100; p_w = 100; p_ar = 100; r_lat = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_corrupt();
        test_lfsr();
        test_wrap_and_zero();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
